// File: rtl/status_pkg.sv
// Shared types and helpers for the status event reporter: the per-entry status
// record, its reset value, the reporter FSM states and the flat index mapping.
package status_pkg;

  typedef struct packed {
    logic a;
    logic b;
  } status_t;

  localparam status_t STATUS_RESET = '0;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } rep_state_t;

  // Flat entry index used by pending_o and held storage: i = g*lanes + l.
  function automatic int unsigned flat_idx(input int unsigned g,
                                           input int unsigned l,
                                           input int unsigned lanes);
    return g * lanes + l;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request bit at or
// after ptr, wrapping around to index 0.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  int unsigned j;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/status_event_reporter.sv
// Watches a group/lane status array, keeps one coalesced pending event per
// entry and drains them round-robin over a valid/ready event port.
module status_event_reporter
  import status_pkg::*;
#(
  parameter  int GROUPS = 2,
  parameter  int LANES  = 2,
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int N      = GROUPS * LANES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  status_t [GROUPS-1:0][LANES-1:0]    status_in,
  output logic                               evt_valid,
  input  logic                               evt_ready,
  output logic [GW-1:0]                      evt_group,
  output logic [LW-1:0]                      evt_lane,
  output status_t                            evt_status,
  output logic [N-1:0]                       pending_o,
  output logic                               overflow_o,
  input  logic                               clear_i
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshake: an event transfers on a rising clk edge where evt_valid and
  // evt_ready are both 1; while evt_valid=1 every evt_* output stays stable.

  status_t [GROUPS-1:0][LANES-1:0] prev_q;
  status_t [N-1:0]                 held_q, held_d;
  logic    [N-1:0]                 pending_q, pending_d, chg;
  logic                            overflow_q, overflow_d;
  logic    [IW-1:0]                ptr_q, ptr_d, sel_q, sel_d, pick_ptr, next_ptr;
  rep_state_t                      state_q, state_d;
  logic    [GW-1:0]                grp_q, grp_d;
  logic    [LW-1:0]                lane_q, lane_d;
  status_t                         evt_status_q, evt_status_d;

  logic            handshake, load, gnt_valid;
  logic [N-1:0]    req;
  logic [IW-1:0]   gnt_idx;
  int unsigned     fi;

  // clear_i suppresses new loads so no cleared entry slips out as an event.
  assign req = clear_i ? '0 : pending_q;

  rr_pick #(.N(N)) u_pick (
    .req       (req),
    .ptr       (pick_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    handshake = (state_q == S_PRESENT) && evt_ready;
    next_ptr  = (sel_q == IW'(N - 1)) ? '0 : sel_q + 1'b1;
    pick_ptr  = handshake ? next_ptr : ptr_q;
    load      = gnt_valid && ((state_q == S_IDLE) || handshake);

    chg    = '0;
    held_d = held_q;
    fi     = 0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int l = 0; l < LANES; l++) begin
        fi      = flat_idx(g, l, LANES);
        chg[fi] = (status_in[g][l] != prev_q[g][l]);
        if (chg[fi]) held_d[fi] = status_in[g][l];
      end
    end

    pending_d  = pending_q;
    overflow_d = clear_i ? 1'b0 : overflow_q;
    for (int i = 0; i < N; i++) begin
      if (clear_i) pending_d[i] = 1'b0;
      if (load && (gnt_idx == IW'(i))) pending_d[i] = 1'b0;
      if (chg[i]) begin
        pending_d[i] = 1'b1;
        // A change racing its own load is a fresh event, not a lost one.
        if (pending_q[i] && !(load && (gnt_idx == IW'(i)))) overflow_d = 1'b1;
      end
    end

    state_d      = state_q;
    ptr_d        = handshake ? next_ptr : ptr_q;
    sel_d        = sel_q;
    grp_d        = grp_q;
    lane_d       = lane_q;
    evt_status_d = evt_status_q;
    if (load) begin
      sel_d        = gnt_idx;
      grp_d        = GW'(int'(gnt_idx) / LANES);
      lane_d       = LW'(int'(gnt_idx) % LANES);
      evt_status_d = held_q[gnt_idx];
    end

    unique case (state_q)
      S_IDLE:    if (load) state_d = S_PRESENT;
      S_PRESENT: if (handshake && !load) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      held_q       <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      ptr_q        <= '0;
      sel_q        <= '0;
      state_q      <= S_IDLE;
      grp_q        <= '0;
      lane_q       <= '0;
      evt_status_q <= STATUS_RESET;
    end else begin
      prev_q       <= status_in;
      held_q       <= held_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      state_q      <= state_d;
      grp_q        <= grp_d;
      lane_q       <= lane_d;
      evt_status_q <= evt_status_d;
    end
  end

  assign evt_valid  = (state_q == S_PRESENT);
  assign evt_group  = grp_q;
  assign evt_lane   = lane_q;
  assign evt_status = evt_status_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_status_event_reporter.sv
// Directed bench for status_event_reporter (2 groups x 2 lanes) with
// hand-computed expectations checked by immediate assertions.
module tb_status_event_reporter;
  import status_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  status_t [1:0][1:0]      status_in;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [0:0]              evt_group;
  logic [0:0]              evt_lane;
  status_t                 evt_status;
  logic [3:0]              pending_o;
  logic                    overflow_o;
  logic                    clear_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int hs;
  int cnt [4];

  status_event_reporter #(.GROUPS(2), .LANES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .status_in  (status_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_group  (evt_group),
    .evt_lane   (evt_lane),
    .evt_status (evt_status),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .clear_i    (clear_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input string tag, input logic [0:0] g, input logic [0:0] l,
                           input logic [1:0] st);
    check({tag, ".valid"},  32'(evt_valid), 32'h1);
    check({tag, ".group"},  32'(evt_group), 32'(g));
    check({tag, ".lane"},   32'(evt_lane), 32'(l));
    check({tag, ".status"}, 32'(evt_status), 32'(st));
  endtask

  initial begin
    rst_n     = 1'b0;
    status_in = '0;
    evt_ready = 1'b0;
    clear_i   = 1'b0;
    step();
    step();
    check("rst.valid",    32'(evt_valid), 32'h0);
    check("rst.pending",  32'(pending_o), 32'h0);
    check("rst.overflow", 32'(overflow_o), 32'h0);
    check("rst.evt",      {28'h0, evt_group, evt_lane, evt_status}, 32'h0);
    rst_n = 1'b1;
    step();

    // Every entry goes to {a=1,b=0}: four back-to-back events in index order.
    for (int g = 0; g < 2; g++)
      for (int l = 0; l < 2; l++) status_in[g][l] = 2'b10;
    evt_ready = 1'b1;
    step();
    check("t1.valid_lat", 32'(evt_valid), 32'h0);
    check("t1.pending",   32'(pending_o), 32'hF);
    step();
    check_evt("t1.e0", 1'b0, 1'b0, 2'b10);
    check("t1.pend0", 32'(pending_o), 32'hE);
    step();
    check_evt("t1.e1", 1'b0, 1'b1, 2'b10);
    step();
    check_evt("t1.e2", 1'b1, 1'b0, 2'b10);
    step();
    check_evt("t1.e3", 1'b1, 1'b1, 2'b10);
    check("t1.pend3", 32'(pending_o), 32'h0);
    step();
    check("t1.idle", 32'(evt_valid), 32'h0);

    // Coalescing: entry (0,0) holds the port while (1,0) changes twice.
    evt_ready = 1'b0;
    status_in[0][0] = 2'b00;
    step();
    check("t2.pend_a", 32'(pending_o), 32'h1);
    step();
    check_evt("t2.hold", 1'b0, 1'b0, 2'b00);
    status_in[1][0] = 2'b01;
    step();
    check("t2.pend_b", 32'(pending_o), 32'h4);
    check("t2.ovf_b",  32'(overflow_o), 32'h0);
    status_in[1][0] = 2'b11;
    step();
    check("t2.pend_c", 32'(pending_o), 32'h4);
    check("t2.ovf_c",  32'(overflow_o), 32'h1);
    check_evt("t2.frozen", 1'b0, 1'b0, 2'b00);
    evt_ready = 1'b1;
    step();
    check_evt("t2.coal", 1'b1, 1'b0, 2'b11);
    check("t2.pend_d", 32'(pending_o), 32'h0);
    step();
    check("t2.idle", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;
    clear_i   = 1'b1;
    step();
    clear_i   = 1'b0;
    check("t2.ovf_clr", 32'(overflow_o), 32'h0);

    // Entry (0,1) changes again in the cycle it is loaded.
    status_in[0][1] = 2'b01;
    step();
    check("t3.pend_a", 32'(pending_o), 32'h2);
    status_in[0][1] = 2'b00;
    step();
    check_evt("t3.old", 1'b0, 1'b1, 2'b01);
    check("t3.pend_b", 32'(pending_o), 32'h2);
    check("t3.ovf_b",  32'(overflow_o), 32'h0);
    evt_ready = 1'b1;
    step();
    check_evt("t3.new", 1'b0, 1'b1, 2'b00);
    check("t3.pend_c", 32'(pending_o), 32'h0);
    check("t3.ovf_c",  32'(overflow_o), 32'h0);
    step();
    check("t3.idle", 32'(evt_valid), 32'h0);

    // clear_i with entry 0 presented and entry 3 pending (and overflowed).
    evt_ready = 1'b0;
    status_in[0][0] = 2'b11;
    step();
    check("t4.pend_a", 32'(pending_o), 32'h1);
    status_in[1][1] = 2'b01;
    step();
    check_evt("t4.pres", 1'b0, 1'b0, 2'b11);
    check("t4.pend_b", 32'(pending_o), 32'h8);
    status_in[1][1] = 2'b00;
    step();
    check("t4.ovf_set", 32'(overflow_o), 32'h1);
    clear_i = 1'b1;
    status_in[1][0] = 2'b10;
    step();
    clear_i = 1'b0;
    check("t4.pend_clr", 32'(pending_o), 32'h4);
    check("t4.ovf_clr",  32'(overflow_o), 32'h0);
    check_evt("t4.kept", 1'b0, 1'b0, 2'b11);
    evt_ready = 1'b1;
    step();
    check_evt("t4.win", 1'b1, 1'b0, 2'b10);
    check("t4.pend_d", 32'(pending_o), 32'h0);
    step();
    check("t4.idle", 32'(evt_valid), 32'h0);
    check("t4.dropped", 32'(pending_o), 32'h0);

    // Continuous toggling: round-robin fairness over 40 handshakes.
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    hs = 0;
    for (int c = 0; c < 100 && hs < 40; c++) begin
      status_in = ~status_in;
      step();
      if (evt_valid) begin
        cnt[int'(evt_group) * 2 + int'(evt_lane)]++;
        hs++;
      end
    end
    check("t5.handshakes", 32'(hs), 32'd40);
    for (int i = 0; i < 4; i++) check($sformatf("t5.cnt%0d", i), 32'(cnt[i]), 32'd10);

    // Asynchronous reset while an event is stalled.
    evt_ready = 1'b0;
    step();
    check("t6.stalled", 32'(evt_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6.async_valid", 32'(evt_valid), 32'h0);
    check("t6.async_evt",   {28'h0, evt_group, evt_lane, evt_status}, 32'h0);
    check("t6.async_pend",  32'(pending_o), 32'h0);
    check("t6.async_ovf",   32'(overflow_o), 32'h0);
    status_in = '0;
    step();
    step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step();
    step();
    step();
    check("t6.no_stale", 32'(evt_valid), 32'h0);
    check("t6.no_pend",  32'(pending_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
